// File: rtl/ad5667_i2c_writer_if.sv
`timescale 1ns/1ps
// ad5667_i2c_writer_if: valid/ready command port and completion status for the AD5667 I2C writer.
interface ad5667_i2c_writer_if;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;
  logic        nack;

  // Register/control side: issues requests, observes status.
  modport master (
    output cmd, data, valid,
    input  ready, busy, done, nack
  );

  // Writer side: accepts requests, reports status.
  modport slave (
    input  cmd, data, valid,
    output ready, busy, done, nack
  );
endinterface

// File: rtl/ad5667_i2c_writer.sv
`timescale 1ns/1ps
// ad5667_i2c_writer: I2C master issuing 4-byte writes ({addr,W}, cmd, MSB, LSB) to an AD5667.
// Write-only, open-drain pad controls, per-transaction NACK report.
// Optional SCL clock stretching: define AD5667_WRITER_STRETCH_EN.
module ad5667_i2c_writer #(
  parameter logic [6:0]  I2C_ADDR = 7'h0C,
  parameter int unsigned CLK_DIV  = 63
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ad5667_i2c_writer_if.slave cmd_if,
  input  logic               scl_i,
  output logic               scl_oe_o,
  input  logic               sda_i,
  output logic               sda_oe_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP
  } state_t;

  state_t           state;
  logic [1:0]       qtr;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       shreg;
  logic [23:0]      pend;
  logic             nack_flag;
  logic [CNT_W-1:0] cnt;

  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             nack_q;

  logic             accept_c;
  logic             tick_c;
  logic             hold_c;

  assign cmd_if.ready = ready_q;
  assign cmd_if.busy  = busy_q;
  assign cmd_if.done  = done_q;
  assign cmd_if.nack  = nack_q;

  assign accept_c = cmd_if.valid & ready_q;
  assign tick_c   = ~hold_c & (cnt == CNT_W'(CLK_DIV - 1));

`ifdef AD5667_WRITER_STRETCH_EN
  // While SCL is released, a slave holding it low freezes the quarter timer.
  assign hold_c = ((state == BIT) || (state == ACK) || (state == STOP)) &&
                  (qtr == 2'd1) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold_c     = 1'b0;
`endif

  // Quarter-period timer; idles at zero so a new transaction starts a fresh quarter.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state == IDLE) || tick_c || hold_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Transaction FSM; pad controls change on the tick that enters each quarter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      qtr       <= 2'd0;
      bit_idx   <= 3'd7;
      byte_idx  <= 2'd0;
      shreg     <= 8'h00;
      pend      <= 24'h000000;
      nack_flag <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_oe_o  <= 1'b0;
      sda_oe_o  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      nack_q <= 1'b0;
      case (state)
        IDLE: begin
          scl_oe_o <= 1'b0;
          sda_oe_o <= 1'b0;
          if (accept_c) begin
            shreg     <= {I2C_ADDR, 1'b0};
            pend      <= {cmd_if.cmd, cmd_if.data};
            nack_flag <= 1'b0;
            qtr       <= 2'd0;
            bit_idx   <= 3'd7;
            byte_idx  <= 2'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state     <= START;
          end
        end

        // q0 bus idle, q1 SDA falls with SCL high, q2 SCL falls.
        START: begin
          if (tick_c) begin
            case (qtr)
              2'd0: begin
                sda_oe_o <= 1'b1;
                qtr      <= 2'd1;
              end
              2'd1: begin
                scl_oe_o <= 1'b1;
                qtr      <= 2'd2;
              end
              default: begin
                sda_oe_o <= ~shreg[7];
                bit_idx  <= 3'd7;
                qtr      <= 2'd0;
                state    <= BIT;
              end
            endcase
          end
        end

        // One data bit: SDA set while SCL low, SCL released for q1/q2, pulled at q3.
        BIT: begin
          if (tick_c) begin
            case (qtr)
              2'd0: begin
                scl_oe_o <= 1'b0;
                qtr      <= 2'd1;
              end
              2'd1: begin
                qtr <= 2'd2;
              end
              2'd2: begin
                scl_oe_o <= 1'b1;
                qtr      <= 2'd3;
              end
              default: begin
                qtr <= 2'd0;
                if (bit_idx == 3'd0) begin
                  sda_oe_o <= 1'b0;
                  state    <= ACK;
                end else begin
                  bit_idx  <= bit_idx - 3'd1;
                  shreg    <= {shreg[6:0], 1'b0};
                  sda_oe_o <= ~shreg[6];
                end
              end
            endcase
          end
        end

        // Ninth clock: SDA released, slave response sampled at the end of q2.
        ACK: begin
          if (tick_c) begin
            case (qtr)
              2'd0: begin
                scl_oe_o <= 1'b0;
                qtr      <= 2'd1;
              end
              2'd1: begin
                qtr <= 2'd2;
              end
              2'd2: begin
                if (sda_i) begin
                  nack_flag <= 1'b1;
                end
                scl_oe_o <= 1'b1;
                qtr      <= 2'd3;
              end
              default: begin
                qtr <= 2'd0;
                if (nack_flag || (byte_idx == 2'd3)) begin
                  sda_oe_o <= 1'b1;
                  state    <= STOP;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                  shreg    <= pend[23:16];
                  pend     <= {pend[15:0], 8'h00};
                  bit_idx  <= 3'd7;
                  sda_oe_o <= ~pend[23];
                  state    <= BIT;
                end
              end
            endcase
          end
        end

        // q0 both low, q1 SCL rises, q2 SDA rises (stop condition), q3 bus-free hold.
        STOP: begin
          if (tick_c) begin
            case (qtr)
              2'd0: begin
                scl_oe_o <= 1'b0;
                qtr      <= 2'd1;
              end
              2'd1: begin
                sda_oe_o <= 1'b0;
                qtr      <= 2'd2;
              end
              2'd2: begin
                qtr <= 2'd3;
              end
              default: begin
                qtr     <= 2'd0;
                done_q  <= 1'b1;
                nack_q  <= nack_flag;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                state   <= IDLE;
              end
            endcase
          end
        end

        default: begin
          state    <= IDLE;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          scl_oe_o <= 1'b0;
          sda_oe_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad5667_i2c_writer.sv
`timescale 1ns/1ps
// tb_ad5667_i2c_writer: AD5667 I2C writer with pulled-up open-drain bus and a behavioural DAC slave.
// Expected results are queued at request time and checked by a monitor at each done pulse.
module tb_ad5667_i2c_writer;

  localparam int FULL_LAT = 151 * 4 + 1;
  localparam int NACK_LAT = 43 * 4 + 1;

  typedef struct packed {
    logic        nack;
    int          lat;
    logic [31:0] bytes;
    int          pulses;
    logic [15:0] va;
    logic [15:0] vb;
  } exp_t;

  logic clk;
  logic rst;
  logic scl_oe, sda_oe;
  logic stretch, slv_sda;
  logic scl, sda;

  ad5667_i2c_writer_if bus ();

  ad5667_i2c_writer #(
    .I2C_ADDR(7'h0C),
    .CLK_DIV (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cmd_if  (bus),
    .scl_i   (scl),
    .scl_oe_o(scl_oe),
    .sda_i   (sda),
    .sda_oe_o(sda_oe)
  );

  // Pull-ups with open-drain pulls from master and slave.
  assign scl = ~(scl_oe | stretch);
  assign sda = ~(sda_oe | slv_sda);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_done = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic n, input int lat, input logic [31:0] b,
                              input int p, input logic [15:0] va, input logic [15:0] vb);
    exp_t e;
    e.nack = n; e.lat = lat; e.bytes = b; e.pulses = p; e.va = va; e.vb = vb;
    return e;
  endfunction

  // AD5667 behavioural slave.
  logic [6:0]  model_addr;
  logic [15:0] m_va, m_vb;
  logic [31:0] m_rx;
  logic [7:0]  m_sh;
  logic        m_active, m_ack;
  logic        p_scl, p_sda;
  int          m_bits, m_nb, m_pulses;

  task automatic apply_cmd(input logic [7:0] c, input logic [15:0] d);
    if (c[5:3] == 3'b011) begin
      if (c[2:0] == 3'b000 || c[2:0] == 3'b111) m_va = d;
      if (c[2:0] == 3'b001 || c[2:0] == 3'b111) m_vb = d;
    end
  endtask

  always @(scl, sda) begin
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
      m_active = 1'b1; m_ack = 1'b0; m_bits = 0; m_nb = 0; m_pulses = 0;
      m_rx = 32'h0; slv_sda = 1'b0;
    end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
      m_active = 1'b0;
    end else if (p_scl !== 1'b1 && scl === 1'b1) begin
      m_pulses++;
      if (m_active && !m_ack) begin
        m_sh = {m_sh[6:0], sda};
        m_bits++;
      end
    end else if (p_scl === 1'b1 && scl === 1'b0) begin
      if (m_ack) begin
        slv_sda = 1'b0; m_ack = 1'b0; m_bits = 0;
      end else if (m_active && m_bits == 8 && m_nb < 4) begin
        m_rx[31 - 8 * m_nb -: 8] = m_sh;
        m_nb++;
        if (m_nb == 1 && m_sh != {model_addr, 1'b0}) begin
          m_active = 1'b0;
        end else begin
          slv_sda = 1'b1; m_ack = 1'b1;
          if (m_nb == 4) apply_cmd(m_rx[23:16], m_rx[15:0]);
        end
      end
    end
    p_scl = scl;
    p_sda = sda;
  end

  // Monitor: compare each completed transaction against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done_o=1, expected no completion (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("nack", bus.nack, e.nack);
          chk("latency", cyc - acc_cyc + 1, e.lat);
          chk("bus_bytes", m_rx, e.bytes);
          chk("scl_pulses", m_pulses, e.pulses);
          chk("vouta", m_va, e.va);
          chk("voutb", m_vb, e.vb);
          chk("ready_at_done", bus.ready, 1);
          chk("busy_at_done", bus.busy, 0);
        end
      end
      if (bus.valid === 1'b1 && bus.ready === 1'b1 && rst === 1'b0) acc_cyc = cyc + 1;
    end
  end

  task automatic send(input logic [7:0] c, input logic [15:0] d, input exp_t e,
                      input bit keep, input bit push);
    bus.cmd = c; bus.data = d; bus.valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        if (push) q.push_back(e);
        @(posedge clk); #1;
        if (!keep) bus.valid = 1'b0;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL accept_timeout: got ready_o=0, expected 1 within 3000 clk");
    bus.valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_pending", q.size(), 0);
    q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1; stretch = 1'b0; slv_sda = 1'b0;
    bus.valid = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000;
    model_addr = 7'h0C; m_va = 16'h0000; m_vb = 16'h0000;
    m_active = 1'b0; m_ack = 1'b0; m_bits = 0; m_nb = 0; m_pulses = 0; m_rx = 32'h0; m_sh = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_nack", bus.nack, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Write-and-update DAC A.
    send(8'h18, 16'hBEEF, mk(1'b0, FULL_LAT, 32'h1818BEEF, 37, 16'hBEEF, 16'h0000), 1'b0, 1'b1);
    drain();

    // Both DACs, then an input-register-only write back-to-back.
    send(8'h1F, 16'h1234, mk(1'b0, FULL_LAT, 32'h181F1234, 37, 16'h1234, 16'h1234), 1'b1, 1'b1);
    send(8'h00, 16'h5555, mk(1'b0, FULL_LAT, 32'h18005555, 37, 16'h1234, 16'h1234), 1'b0, 1'b1);
    drain();

    // Slave strapped to a different address: address NACK.
    model_addr = 7'h0F;
    send(8'h18, 16'hAAAA, mk(1'b1, NACK_LAT, 32'h18000000, 10, 16'h1234, 16'h1234), 1'b0, 1'b1);
    drain();
    model_addr = 7'h0C;

    // Request while busy is dropped.
    d0 = n_done;
    send(8'h18, 16'h4321, mk(1'b0, FULL_LAT, 32'h18184321, 37, 16'h4321, 16'h1234), 1'b0, 1'b1);
    repeat (50 * 4 - 1) @(posedge clk);
    #1 bus.cmd = 8'h1F; bus.data = 16'h0000; bus.valid = 1'b1;
    @(posedge clk); #1 bus.valid = 1'b0;
    drain();
    repeat (700) @(posedge clk); #1;
    chk("single_done", n_done - d0, 1);
    chk("vouta_after_ignored", m_va, 16'h4321);

    // Reset in the middle of data MSB bit 3.
    d0 = n_done;
    send(8'h18, 16'h0BAD, mk(1'b0, 0, 32'h0, 0, 16'h0, 16'h0), 1'b0, 1'b0);
    repeat (92 * 4) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", bus.busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_busy", bus.busy, 0);
    repeat (700) @(posedge clk); #1;
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_vouta", m_va, 16'h4321);

    // Reset and request in the same cycle: request dropped.
    bus.cmd = 8'h18; bus.data = 16'h9999; bus.valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.valid = 1'b0;
    @(negedge clk);
    chk("rstvalid_busy", bus.busy, 0);
    chk("rstvalid_ready", bus.ready, 1);
    @(posedge clk); #1;

    // Normal operation after reset.
    send(8'h18, 16'h0F0F, mk(1'b0, FULL_LAT, 32'h18180F0F, 37, 16'h0F0F, 16'h1234), 1'b0, 1'b1);
    drain();

`ifdef AD5667_WRITER_STRETCH_EN
    // Slave holds SCL low for 10 clk at the byte-1 ACK clock.
    fork
      begin
        int pulls;
        logic prev;
        pulls = 0;
        prev = scl_oe;
        for (int i = 0; i < 2000 && pulls < 18; i++) begin
          @(posedge clk); #1;
          if (!prev && scl_oe) pulls++;
          prev = scl_oe;
        end
        stretch = 1'b1;
        repeat (8 + 10) @(posedge clk);
        #1 stretch = 1'b0;
      end
    join_none
    send(8'h18, 16'h7777, mk(1'b0, FULL_LAT + 10, 32'h18187777, 37, 16'h7777, 16'h1234), 1'b0, 1'b1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
